// File: rtl/input_quantizer_packer.sv
// Quantizes signed feature samples to OUT_BITS codes and packs NUM_FEATURES of them into one vector.
// Optional clamp counter output sat_count is enabled by defining INQ_SAT_COUNT_EN.
module input_quantizer_packer #(
    parameter int NUM_FEATURES = 16,
    parameter int IN_WIDTH     = 16,
    parameter int OUT_BITS     = 2,
    parameter int SHIFT        = 4,
    parameter int OFFSET       = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [IN_WIDTH-1:0]              s_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [NUM_FEATURES*OUT_BITS-1:0] m_data
`ifdef INQ_SAT_COUNT_EN
    ,
    output logic [$clog2(NUM_FEATURES+1)-1:0] sat_count
`endif
);

    localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int TW    = IN_WIDTH + 2;
    localparam int VW    = NUM_FEATURES * OUT_BITS;
    localparam logic signed [TW-1:0]    OFF_EXT  = TW'(OFFSET);
    localparam logic signed [TW-1:0]    QMAX_EXT = TW'((1 << OUT_BITS) - 1);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_FEATURES - 1);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [VW-1:0]        shadow_q, shadow_d;
    logic [VW-1:0]        data_q, data_d;

    logic signed [TW-1:0] sample_ext;
    logic signed [TW-1:0] t;
    logic [OUT_BITS-1:0]  q;
    logic                 clamped;
    logic                 accept;

    // Two guard bits keep the shift-plus-offset free of overflow for any input.
    always_comb begin
        sample_ext = {{2{s_data[IN_WIDTH-1]}}, s_data};
        t          = (sample_ext >>> SHIFT) + OFF_EXT;
        q          = t[OUT_BITS-1:0];
        clamped    = 1'b0;
        if (t < 0) begin
            q       = '0;
            clamped = 1'b1;
        end else if (t > QMAX_EXT) begin
            q       = '1;
            clamped = 1'b1;
        end
    end

    assign s_ready = (state_q == COLLECT);
    assign m_valid = (state_q == HOLD);
    assign accept  = s_valid && (state_q == COLLECT);
    assign m_data  = data_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        case (state_q)
            COLLECT: begin
                if (s_valid) begin
                    shadow_d[idx_q*OUT_BITS +: OUT_BITS] = q;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        data_d  = shadow_d;
                        state_d = HOLD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= COLLECT;
            idx_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
        end
    end

`ifdef INQ_SAT_COUNT_EN
    localparam int CW = $clog2(NUM_FEATURES + 1);

    logic [CW-1:0] sat_run_q, sat_run_d;
    logic [CW-1:0] sat_out_q, sat_out_d;

    // The running count is published with m_data and restarts for the next vector.
    always_comb begin
        sat_run_d = sat_run_q;
        sat_out_d = sat_out_q;
        if (accept) begin
            if (idx_q == LAST_IDX) begin
                sat_out_d = sat_run_q + CW'(clamped);
                sat_run_d = '0;
            end else begin
                sat_run_d = sat_run_q + CW'(clamped);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_run_q <= '0;
            sat_out_q <= '0;
        end else begin
            sat_run_q <= sat_run_d;
            sat_out_q <= sat_out_d;
        end
    end

    assign sat_count = sat_out_q;
`endif

endmodule

// File: tb/tb_input_quantizer_packer.sv
// Directed self-checking bench for input_quantizer_packer with NUM_FEATURES=4, OUT_BITS=2, SHIFT=4, OFFSET=2.
// Covers reset, quantize/clamp, backpressure, mid-vector reset, gapped traffic and full-rate throughput.
module tb_input_quantizer_packer;

    localparam int NF = 4;
    localparam int IW = 16;
    localparam int OB = 2;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [IW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [NF*OB-1:0] m_data;
`ifdef INQ_SAT_COUNT_EN
    logic [2:0]    sat_count;
`endif

    int testCount = 0;
    int failCount = 0;

    input_quantizer_packer #(
        .NUM_FEATURES(NF),
        .IN_WIDTH    (IW),
        .OUT_BITS    (OB),
        .SHIFT       (4),
        .OFFSET      (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
`ifdef INQ_SAT_COUNT_EN
        ,
        .sat_count(sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the sample was taken.
    task automatic applyStimulus(input logic [IW-1:0] d);
        int tries;
        s_valid = 1'b1;
        s_data  = d;
        tries   = 0;
        while (!s_ready && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 100) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 'x;
    endtask

    task automatic releaseVector();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    function automatic logic [1:0] refCode(input logic [IW-1:0] d);
        int t;
        t = (int'($signed(d)) >>> 4) + 2;
        if (t < 0) return 2'd0;
        if (t > 3) return 2'd3;
        return t[1:0];
    endfunction

    logic [IW-1:0]    vec [NF];
    logic [NF*OB-1:0] expVec;
    logic [NF*OB-1:0] held;
    int               lowCount;
    int               validCount;

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
        checkOutput("reset_m_data", 32'(m_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic quantize and pack, latency one cycle after the last handshake.
        applyStimulus(16'd0);
        applyStimulus(16'd16);
        applyStimulus(-16'sd16);
        checkOutput("t1_no_early_valid", 32'(m_valid), 32'd0);
        applyStimulus(-16'sd48);
        checkOutput("t1_m_valid", 32'(m_valid), 32'd1);
        checkOutput("t1_m_data", 32'(m_data), 32'b00_01_11_10);
        checkOutput("t1_s_ready_low", 32'(s_ready), 32'd0);
        releaseVector();
        checkOutput("t1_m_valid_drop", 32'(m_valid), 32'd0);
        checkOutput("t1_s_ready_back", 32'(s_ready), 32'd1);
        checkOutput("t1_m_data_kept", 32'(m_data), 32'b00_01_11_10);

        // Clamping at both ends.
        applyStimulus(16'd100);
        applyStimulus(16'h8000);
        applyStimulus(16'h7FFF);
        applyStimulus(16'd31);
        checkOutput("t2_m_data", 32'(m_data), 32'b11_11_00_11);
`ifdef INQ_SAT_COUNT_EN
        checkOutput("t2_sat_count", 32'(sat_count), 32'd3);
`endif

        // Backpressure in HOLD with s_valid asserted must not consume samples.
        held = m_data;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = IW'($urandom);
            @(negedge clk);
        end
        checkOutput("t3_m_data_stable", 32'(m_data), 32'(held));
        checkOutput("t3_m_valid_held", 32'(m_valid), 32'd1);
        checkOutput("t3_s_ready_low", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        releaseVector();
        applyStimulus(16'd0);
        applyStimulus(16'd16);
        applyStimulus(-16'sd16);
        applyStimulus(-16'sd48);
        checkOutput("t3_next_vector", 32'(m_data), 32'b00_01_11_10);
        releaseVector();

        // Reset in the middle of a vector discards the partial one.
        applyStimulus(16'h7FFF);
        applyStimulus(16'h7FFF);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t4_m_valid_in_reset", 32'(m_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t4_m_valid_after", 32'(m_valid), 32'd0);
        checkOutput("t4_s_ready_after", 32'(s_ready), 32'd1);
        applyStimulus(16'd16);
        applyStimulus(16'd0);
        checkOutput("t4_no_early_valid", 32'(m_valid), 32'd0);
        applyStimulus(-16'sd48);
        applyStimulus(16'd16);
        checkOutput("t4_m_data", 32'(m_data), 32'b11_00_10_11);
`ifdef INQ_SAT_COUNT_EN
        checkOutput("t4_sat_count", 32'(sat_count), 32'd1);
`endif
        releaseVector();

        // Gapped traffic with random downstream stalls against the reference quantizer.
        for (int v = 0; v < 30; v++) begin
            for (int k = 0; k < NF; k++) begin
                vec[k] = IW'($urandom_range(0, 16'hFFFF));
                if (k == 0 && v % 3 == 0) vec[k] = 16'h8000 + IW'(v);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                applyStimulus(vec[k]);
            end
            expVec = '0;
            for (int k = 0; k < NF; k++) expVec[k*OB +: OB] = refCode(vec[k]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checkOutput($sformatf("t5_vector_%0d", v), {23'd0, m_valid, m_data}, {23'd1, expVec});
            releaseVector();
        end

        // Full rate: one vector every five cycles, s_ready low exactly once per vector.
        lowCount   = 0;
        validCount = 0;
        m_ready    = 1'b1;
        s_valid    = 1'b1;
        s_data     = 16'd16;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!s_ready) lowCount++;
            if (m_valid) validCount++;
            if (c == 3) checkOutput("t6_first_hold_cycle", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        checkOutput("t6_s_ready_low_cycles", 32'(lowCount), 32'd4);
        checkOutput("t6_vectors", 32'(validCount), 32'd4);
        checkOutput("t6_m_data", 32'(m_data), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
